// File: rtl/sudc_param_pkg.sv
// Shared definitions for the sudc_param up/down counter family:
// counting-mode constants, the default width and the per-edge operation
// decode used by the top-level priority mux.
package sudc_param_pkg;

  // Behaviour at the count limits, used for the SATURATE parameter.
  localparam int SUDC_MODE_WRAP = 0;
  localparam int SUDC_MODE_SAT  = 1;

  // Default counter width when an instance does not override WIDTH.
  localparam int SUDC_DEFAULT_WIDTH = 8;

  // What the q register does on a given rising edge.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } sudc_op_e;

  // Resolve the three control inputs into one operation.
  // Clear beats load, and load beats counting.
  function automatic sudc_op_e sudc_select_op(input logic clr,
                                              input logic load,
                                              input logic en);
    sudc_op_e op;
    if (clr)       op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_COUNT;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage : sudc_param_pkg

// File: rtl/sudc_next_val.sv
// Combinational next-count generator for sudc_param.
// Given the current count and direction, produces the value the counter
// moves to on an enabled edge, plus a flag saying whether that step
// touched a limit (wrapped around, or was blocked in saturate mode).
// The increment and decrement are computed one bit wider than the counter,
// so the carry/borrow is the limit test itself and a full-range modulus
// (MAX_VAL = 2**WIDTH-1) cannot alias through truncation.
module sudc_next_val
  import sudc_param_pkg::*;
#(
  parameter int          WIDTH    = SUDC_DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int          SATURATE = SUDC_MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_q,
  output logic             limit_hit
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
  localparam bit               SAT     = (SATURATE == SUDC_MODE_SAT);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           at_max;
  logic           at_zero;

  assign q_ext   = {1'b0, q};
  assign inc_ext = q_ext + 1'b1;
  assign dec_ext = q_ext - 1'b1;

  // Stepping up past MAX_VAL means the widened sum exceeds it; stepping
  // down from 0 borrows into the extra top bit.
  assign at_max  = (inc_ext > MAX_EXT);
  assign at_zero = dec_ext[WIDTH];

  // Pick the next count for the current direction, handling the limits.
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // branches below can leave a value unassigned and infer a latch.
    next_q    = q;
    limit_hit = 1'b0;
    if (up_down) begin
      if (at_max) begin
        limit_hit = 1'b1;
        next_q    = SAT ? q : '0;
      end else begin
        next_q = inc_ext[WIDTH-1:0];
      end
    end else begin
      if (at_zero) begin
        limit_hit = 1'b1;
        next_q    = SAT ? q : MAX_Q;
      end else begin
        next_q = dec_ext[WIDTH-1:0];
      end
    end
  end

endmodule : sudc_next_val

// File: rtl/sudc_param.sv
// Parametrised synchronous up/down counter with programmable width and
// modulus, wrap or saturate behaviour at the limits, enable, synchronous
// clear and parallel load (clamped into range), a combinational
// terminal-count decode, a one-cycle wrap/limit pulse and sticky
// overflow/underflow flags.
// Reset is asynchronous and active-low on rst.
module sudc_param
  import sudc_param_pkg::*;
#(
  parameter int          WIDTH    = SUDC_DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int          SATURATE = SUDC_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];

  // Reject configurations the counter cannot represent.
  if (WIDTH < 2) begin : g_bad_width
    $error("sudc_param: WIDTH must be at least 2");
  end
  if (longint'(MAX_VAL) >= (longint'(1) << WIDTH)) begin : g_bad_max
    $error("sudc_param: MAX_VAL must be below 2**WIDTH");
  end

  sudc_op_e         op;
  logic [WIDTH-1:0] count_q;
  logic             limit_hit;
  logic [WIDTH-1:0] load_q;
  logic             limit_event;
  logic             ovf_event;
  logic             udf_event;

  // Next count for an enabled edge in the current direction.
  sudc_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next_val (
    .q         (q),
    .up_down   (up_down),
    .next_q    (count_q),
    .limit_hit (limit_hit)
  );

  assign op = sudc_select_op(clr, load, en);

  // Out-of-range load values are clamped so q never leaves 0..MAX_VAL.
  assign load_q = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;

  // A limit only counts as an event when the edge actually counts.
  assign limit_event = (op == OP_COUNT) && limit_hit;
  assign ovf_event   = limit_event && up_down;
  assign udf_event   = limit_event && !up_down;

  // Terminal count tracks the direction without waiting for a clock.
  assign tc = up_down ? (q == MAX_Q) : (q == '0);

  // Count register and the one-cycle wrap pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments
      // so every register samples pre-edge values regardless of order.
      wrap <= limit_event;
      unique case (op)
        OP_CLEAR: q <= '0;
        OP_LOAD:  q <= load_q;
        OP_COUNT: q <= count_q;
        default:  q <= q;
      endcase
    end
  end

  // Sticky flags: a limit event on the same edge beats sticky_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_event)       ovf <= 1'b1;
      else if (sticky_clr) ovf <= 1'b0;
      if (udf_event)       udf <= 1'b1;
      else if (sticky_clr) udf <= 1'b0;
    end
  end

endmodule : sudc_param
